lcd_capture: RTL

- Receiver for the parallel RGB565 LCD interface: the same DEN/HSYNC/VSYNC/RGB signalling our panel drivers emit.
- Recovers pixel and line position from the incoming stream.
- Decimates a fixed window 4:1 in each axis and converts each kept pixel to 6-bit luma.
- Writes kept pixels into the 2048x8 video RAM write port, so a captured frame can be replayed by the existing display path.

---
 rtl/lcd_capture.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/lcd_capture.sv
// ---------------------------------------------------------------------------
// lcd_capture
//   Receiver for a parallel RGB565 LCD stream (DEN/HSYNC/VSYNC/RGB).
//   Recovers pixel/line position, keeps every 4th pixel of every 4th line
//   inside a fixed 256x128 window, converts the kept pixels to 6-bit luma
//   and writes them into a 2048x8 video RAM write port (64x32 cells).
//
// Ports
//   pixel_clk   in   1  pixel clock, inputs sampled on the rising edge
//   rst         in   1  asynchronous active-low reset
//   vid_vsync   in   1  frame sync, active level set by VS_POL
//   vid_hsync   in   1  line sync (not used for timing)
//   vid_den     in   1  data enable, high on active pixels
//   vid_r/g/b   in 5/6/5 pixel colour
//   capture_en  in   1  arms capture of the next frame
//   wr_en       out  1  video RAM write strobe
//   wr_addr     out 11  {row[4:0], col[5:0]}
//   wr_data     out  8  {2'b00, luma[5:0]}
//   busy        out  1  high while armed or capturing
//   frame_done  out  1  one-cycle pulse at the end of a captured frame
//   line_err    out  1  sticky: a captured line had the wrong DEN length
//   frame_cnt   out  8  completed captured frames, wrapping
// ---------------------------------------------------------------------------
module lcd_capture #(
  parameter int H_ACTIVE = 480,
  parameter int WIN_X    = 96,
  parameter int WIN_Y    = 64,
  parameter bit VS_POL   = 1'b0
) (
  input  logic        pixel_clk,
  input  logic        rst,
  input  logic        vid_vsync,
  input  logic        vid_hsync,
  input  logic        vid_den,
  input  logic [4:0]  vid_r,
  input  logic [5:0]  vid_g,
  input  logic [4:0]  vid_b,
  input  logic        capture_en,
  output logic        wr_en,
  output logic [10:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy,
  output logic        frame_done,
  output logic        line_err,
  output logic [7:0]  frame_cnt
);

  localparam logic [15:0] H_ACTIVE16 = 16'(H_ACTIVE);
  localparam logic [15:0] WIN_X16    = 16'(WIN_X);
  localparam logic [15:0] WIN_Y16    = 16'(WIN_Y);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE} state_t;

  state_t      state_reg, state_next;
  logic        vsync_q_reg, den_q_reg;
  logic [4:0]  r_q_reg, b_q_reg;
  logic [5:0]  g_q_reg;
  logic        vs_act_d_reg, den_d_reg;
  logic [15:0] x_cnt_reg, y_cnt_reg;
  logic        line_valid_reg;

  logic        vs_act, vs_rise, den_fall, den_rise;
  logic [15:0] xr, yr;
  logic        in_win, keep;
  logic [7:0]  luma_sum;
  logic        frame_end, arm;
  logic [2:0]  unused_bits;

  assign unused_bits = {vid_hsync, luma_sum[1:0]};

  // Input register stage
  always_ff @(posedge pixel_clk or negedge rst) begin
    if (!rst) begin
      // vsync starts inactive so release of reset never looks like a frame start
      vsync_q_reg <= ~VS_POL;
      den_q_reg   <= 1'b0;
      r_q_reg     <= '0;
      g_q_reg     <= '0;
      b_q_reg     <= '0;
    end else begin
      vsync_q_reg <= vid_vsync;
      den_q_reg   <= vid_den;
      r_q_reg     <= vid_r;
      g_q_reg     <= vid_g;
      b_q_reg     <= vid_b;
    end
  end

  assign vs_act   = (vsync_q_reg == VS_POL);
  assign vs_rise  = vs_act & ~vs_act_d_reg;
  assign den_fall = den_d_reg & ~den_q_reg;
  assign den_rise = den_q_reg & ~den_d_reg;

  // Position recovery
  always_ff @(posedge pixel_clk or negedge rst) begin
    if (!rst) begin
      vs_act_d_reg   <= 1'b0;
      den_d_reg      <= 1'b0;
      x_cnt_reg      <= '0;
      y_cnt_reg      <= '0;
      line_valid_reg <= 1'b0;
    end else begin
      vs_act_d_reg <= vs_act;
      den_d_reg    <= den_q_reg;

      if (vs_rise || den_fall)
        x_cnt_reg <= '0;
      else if (den_q_reg)
        x_cnt_reg <= x_cnt_reg + 16'd1;

      if (vs_rise)
        y_cnt_reg <= '0;
      else if (den_fall && (y_cnt_reg != 16'hFFFF))
        y_cnt_reg <= y_cnt_reg + 16'd1;

      // A line cut by vsync has no DEN rise in the new frame, so its
      // trailing DEN fall is never length-checked.
      if (vs_rise)
        line_valid_reg <= 1'b0;
      else if (den_rise)
        line_valid_reg <= 1'b1;
    end
  end

  // Capture control
  always_ff @(posedge pixel_clk or negedge rst) begin
    if (!rst)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    frame_end  = 1'b0;
    arm        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (vs_rise && capture_en) begin
          state_next = ARMED;
          arm        = 1'b1;
        end
      end
      ARMED: begin
        if (den_q_reg)
          state_next = CAPTURE;
      end
      CAPTURE: begin
        if (vs_rise) begin
          frame_end = 1'b1;
          if (capture_en) begin
            state_next = ARMED;
            arm        = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state_reg != IDLE);

  // Window / decimation test. Offsets wrap as unsigned, so pixels left of or
  // above the window fall outside the range compare.
  assign xr     = x_cnt_reg - WIN_X16;
  assign yr     = y_cnt_reg - WIN_Y16;
  assign in_win = (xr < 16'd256) && (yr < 16'd128) &&
                  (xr[1:0] == 2'b00) && (yr[1:0] == 2'b00);
  // The vsync cycle belongs to the next frame, so nothing is written in it.
  assign keep   = (state_reg == CAPTURE) && den_q_reg && !vs_rise && in_win;

  // Full-scale white sums to 250, so luma tops out at 62.
  assign luma_sum = {2'b00, r_q_reg, 1'b0} + {1'b0, g_q_reg, 1'b0} +
                    {2'b00, b_q_reg, 1'b0};

  // Output register stage
  always_ff @(posedge pixel_clk or negedge rst) begin
    if (!rst) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      line_err   <= 1'b0;
    end else begin
      wr_en      <= keep;
      wr_addr    <= {yr[6:2], xr[7:2]};
      wr_data    <= {2'b00, luma_sum[7:2]};
      frame_done <= frame_end;
      frame_cnt  <= frame_cnt + {7'd0, frame_end};
      if (arm)
        line_err <= 1'b0;
      else if ((state_reg == CAPTURE) && den_fall && line_valid_reg &&
               (x_cnt_reg != H_ACTIVE16))
        line_err <= 1'b1;
    end
  end

endmodule
